uart_rx: RTL and testbench

// UART receive engine: the far-end counterpart of the TX engine. Samples the serial line RXD using the

---
 rtl/uart_rx.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- UART receive engine with an internal RX FIFO.
//
// The RXD line is synchronised, then sampled using a 16x baud tick.
// The engine deframes 5-8 data bits, an optional parity bit and one stop bit,
// as selected by LCR. Each received character is pushed into the RX FIFO
// together with its break, framing and parity error flags.
//
// Ports
//   PCLK, PRESETn   clock; asynchronous active-low reset
//   RXD             serial input, idle high, asynchronous to PCLK
//   enable          16x baud tick, one PCLK wide
//   LCR             [1:0] data length 5+n, [3] parity enable, [4] even,
//                   [5] stick parity; other bits are ignored
//   rx_fifo_pop     removes the head entry (ignored when empty)
//   rx_fifo_out     head entry {BI,FE,PE,data[7:0]}, first-word fall-through
//   rx_fifo_empty   FIFO holds no entries
//   rx_fifo_full    FIFO holds FIFO_DEPTH entries
//   rx_fifo_count   number of entries held
//   rx_overrun      sticky flag: a character was lost because the FIFO was full
//   overrun_clr     clears rx_overrun (a new overrun in the same cycle wins)
//   busy            receiver is somewhere other than IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          RXD,
    input  logic          enable,
    input  logic [7:0]    LCR,
    input  logic          rx_fifo_pop,
    output logic [10:0]   rx_fifo_out,
    output logic          rx_fifo_empty,
    output logic          rx_fifo_full,
    output logic [CW-1:0] rx_fifo_count,
    output logic          rx_overrun,
    input  logic          overrun_clr,
    output logic          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             data_q, data_d;
    logic [1:0]             len_q, len_d;      // latched LCR[1:0]
    logic [2:0]             par_q, par_d;      // latched LCR[5:3]
    logic                   par_bit_q, par_bit_d;
    logic                   pe_q, pe_d;
    logic                   push_q, push_d;
    logic [10:0]            entry_q, entry_d;
    logic                   busy_q, busy_d;

    logic       rxd_s;
    logic       mid_tick;
    logic       end_tick;
    logic [2:0] last_bit;
    logic       exp_par;
    logic       fe;
    logic       bi;
    logic       unused_lcr;

    assign unused_lcr = ^{LCR[7:6], LCR[2]};
    assign rxd_s      = sync_q[SYNC_STAGES-1];
    assign mid_tick   = enable && (cnt_q == 4'd7);
    assign end_tick   = enable && (cnt_q == 4'd15);
    assign last_bit   = 3'd4 + {1'b0, len_q};

    // Expected parity bit from the latched stick/even selection.
    always_comb begin
        case (par_q[2:1])
            2'b00:   exp_par = ~^data_q;   // odd
            2'b01:   exp_par = ^data_q;    // even
            2'b10:   exp_par = 1'b1;       // stick 1
            default: exp_par = 1'b0;       // stick 0
        endcase
    end

    // A break is a zero character whose parity bit (if any) and stop bit
    // were both low. par_bit_q is cleared at start, so it reads 0 when
    // parity is disabled.
    assign fe = ~rxd_s;
    assign bi = fe && (data_q == 8'h00) && !par_bit_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], RXD};
        state_d   = state_q;
        cnt_d     = enable ? cnt_q + 4'd1 : cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        len_d     = len_q;
        par_d     = par_q;
        par_bit_d = par_bit_q;
        pe_d      = pe_q;
        push_d    = 1'b0;
        entry_d   = entry_q;

        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d = S_START;
                    cnt_d   = 4'd0;
                end
            end
            S_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (mid_tick) begin
                    if (!rxd_s) begin
                        state_d   = S_DATA;
                        cnt_d     = 4'd0;
                        len_d     = LCR[1:0];
                        par_d     = LCR[5:3];
                        bit_cnt_d = 3'd0;
                        data_d    = 8'h00;
                        par_bit_d = 1'b0;
                        pe_d      = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (end_tick) begin
                    data_d[bit_cnt_q] = rxd_s;
                    bit_cnt_d         = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == last_bit) begin
                        state_d = par_q[0] ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (end_tick) begin
                    par_bit_d = rxd_s;
                    pe_d      = (rxd_s != exp_par);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (end_tick) begin
                    entry_d = {bi, fe, pe_q, data_q};
                    push_d  = 1'b1;
                    state_d = bi ? S_BRK_WAIT : S_IDLE;
                end
            end
            S_BRK_WAIT: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_q    <= '1;
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            bit_cnt_q <= 3'd0;
            data_q    <= 8'h00;
            len_q     <= 2'd0;
            par_q     <= 3'd0;
            par_bit_q <= 1'b0;
            pe_q      <= 1'b0;
            push_q    <= 1'b0;
            entry_q   <= 11'h000;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            len_q     <= len_d;
            par_q     <= par_d;
            par_bit_q <= par_bit_d;
            pe_q      <= pe_d;
            push_q    <= push_d;
            entry_q   <= entry_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [10:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovr_evt;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = rx_fifo_pop && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push = push_q && (!full || do_pop);
    assign ovr_evt = push_q && full && !do_pop;

    always_comb begin
        wr_ptr_d  = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overrun_d = ovr_evt ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 11'h000;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= entry_q;
            end
        end
    end

    assign rx_fifo_out   = mem_q[rd_ptr_q];
    assign rx_fifo_empty = (count_q == '0);
    assign rx_fifo_full  = full;
    assign rx_fifo_count = count_q;
    assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed test of uart_rx.
// The baud tick is high every other PCLK, so one bit lasts 32 PCLKs.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic        clk;
    logic        PRESETn;
    logic        RXD;
    logic        enable;
    logic [7:0]  LCR;
    logic        rx_fifo_pop;
    logic [10:0] rx_fifo_out;
    logic        rx_fifo_empty;
    logic        rx_fifo_full;
    logic [4:0]  rx_fifo_count;
    logic        rx_overrun;
    logic        overrun_clr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    localparam int BIT_CLKS = 32;

    uart_rx #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .PCLK          (clk),
        .PRESETn       (PRESETn),
        .RXD           (RXD),
        .enable        (enable),
        .LCR           (LCR),
        .rx_fifo_pop   (rx_fifo_pop),
        .rx_fifo_out   (rx_fifo_out),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_full  (rx_fifo_full),
        .rx_fifo_count (rx_fifo_count),
        .rx_overrun    (rx_overrun),
        .overrun_clr   (overrun_clr),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick: one PCLK high, one PCLK low, changing on the falling edge.
    initial begin
        enable = 1'b0;
        forever begin
            @(negedge clk);
            enable = ~enable;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sends one frame LSB first. The start bit is driven on the falling edge
    // just before a tick-high cycle so sampling points are repeatable.
    // pop_at >= 1 raises rx_fifo_pop for the cycle after the pop_at'th
    // falling edge of the frame.
    task automatic send_frame(input logic [7:0] data, input int nbits,
                              input bit par_en, input logic par_bit,
                              input logic stop_bit, input int pop_at);
        logic [11:0] frame;
        int idx;
        int n;
        frame = 12'h000;
        for (int i = 0; i < nbits; i++) frame[1+i] = data[i];
        idx = 1 + nbits;
        if (par_en) begin
            frame[idx] = par_bit;
            idx++;
        end
        frame[idx] = stop_bit;
        @(posedge clk);
        while (enable !== 1'b0) @(posedge clk);
        @(negedge clk);
        n = 0;
        for (int b = 0; b <= idx; b++) begin
            RXD = frame[b];
            repeat (BIT_CLKS) begin
                @(negedge clk);
                n++;
                rx_fifo_pop = (n == pop_at);
            end
        end
        rx_fifo_pop = 1'b0;
        RXD = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; RXD = 1'b1; LCR = 8'h03;
        rx_fifo_pop = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rx_fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", rx_fifo_empty); end
        total++; if (rx_fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", rx_fifo_full); end
        total++; if (rx_fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", rx_fifo_count); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
        total++; if (rx_fifo_out !== 11'h000) begin bad++; $display("FAIL reset_out got=%h exp=000", rx_fifo_out); end
        PRESETn = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        $display("test_reset: done");
    endtask

    task automatic test_8n1();
        LCR = 8'h03;
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
            begin
                repeat (100) @(negedge clk);
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL 8n1_busy_mid got=%b exp=1", busy); end
            end
        join
        total++; if (rx_fifo_count !== 5'd1) begin bad++; $display("FAIL 8n1_count got=%0d exp=1", rx_fifo_count); end
        total++; if (rx_fifo_out !== 11'h0A5) begin bad++; $display("FAIL 8n1_data got=%h exp=0a5", rx_fifo_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL 8n1_busy_end got=%b exp=0", busy); end
        rx_fifo_pop = 1'b1; @(negedge clk); rx_fifo_pop = 1'b0;
        total++; if (rx_fifo_empty !== 1'b1) begin bad++; $display("FAIL 8n1_pop_empty got=%b exp=1", rx_fifo_empty); end
        $display("test_8n1: char 0xA5 received as %h", 11'h0A5);
    endtask

    task automatic test_parity();
        LCR = 8'h1B;  // 8 bits, even parity; 0x3C has four ones -> parity 0
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, -1);
        total++; if (rx_fifo_out !== 11'h13C) begin bad++; $display("FAIL parity_bad got=%h exp=13c", rx_fifo_out); end
        rx_fifo_pop = 1'b1; @(negedge clk); rx_fifo_pop = 1'b0;
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, -1);
        total++; if (rx_fifo_out !== 11'h03C) begin bad++; $display("FAIL parity_good got=%h exp=03c", rx_fifo_out); end
        rx_fifo_pop = 1'b1; @(negedge clk); rx_fifo_pop = 1'b0;
        $display("test_parity: two characters checked");
    endtask

    task automatic test_5bit();
        LCR = 8'h00;
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, -1);
        total++; if (rx_fifo_out !== 11'h01F) begin bad++; $display("FAIL 5bit_data got=%h exp=01f", rx_fifo_out); end
        rx_fifo_pop = 1'b1; @(negedge clk); rx_fifo_pop = 1'b0;
        fork
            send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, -1);
            begin
                repeat (100) @(negedge clk);
                LCR = 8'h03;
            end
        join
        repeat (200) @(negedge clk);
        total++; if (rx_fifo_count !== 5'd1) begin bad++; $display("FAIL 5bit_lcrchg_count got=%0d exp=1", rx_fifo_count); end
        total++; if (rx_fifo_out !== 11'h01F) begin bad++; $display("FAIL 5bit_lcrchg_data got=%h exp=01f", rx_fifo_out); end
        rx_fifo_pop = 1'b1; @(negedge clk); rx_fifo_pop = 1'b0;
        $display("test_5bit: two characters checked");
    endtask

    task automatic test_false_start();
        LCR = 8'h03;
        @(posedge clk);
        while (enable !== 1'b0) @(posedge clk);
        @(negedge clk);
        RXD = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fstart_busy got=%b exp=1", busy); end
        repeat (2) @(negedge clk);
        RXD = 1'b1;
        repeat (40) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fstart_idle got=%b exp=0", busy); end
        total++; if (rx_fifo_count !== 5'd0) begin bad++; $display("FAIL fstart_count got=%0d exp=0", rx_fifo_count); end
        $display("test_false_start: 5-tick low pulse");
    endtask

    task automatic test_break();
        LCR = 8'h0B;  // 8 bits, odd parity: zero data with parity 0 gives PE too
        @(posedge clk);
        while (enable !== 1'b0) @(posedge clk);
        @(negedge clk);
        RXD = 1'b0;
        repeat (3 * 11 * BIT_CLKS) @(negedge clk);
        total++; if (rx_fifo_count !== 5'd1) begin bad++; $display("FAIL brk_count got=%0d exp=1", rx_fifo_count); end
        total++; if (rx_fifo_out !== 11'h700) begin bad++; $display("FAIL brk_entry got=%h exp=700", rx_fifo_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL brk_wait_busy got=%b exp=1", busy); end
        RXD = 1'b1;
        repeat (64) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL brk_release got=%b exp=0", busy); end
        total++; if (rx_fifo_count !== 5'd1) begin bad++; $display("FAIL brk_one_entry got=%0d exp=1", rx_fifo_count); end
        rx_fifo_pop = 1'b1; @(negedge clk); rx_fifo_pop = 1'b0;
        $display("test_break: one entry 700");
    endtask

    task automatic test_overflow();
        logic [10:0] exp;
        LCR = 8'h03;
        for (int i = 1; i <= 16; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, -1);
        total++; if (rx_fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count16 got=%0d exp=16", rx_fifo_count); end
        total++; if (rx_fifo_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", rx_fifo_full); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", rx_overrun); end
        send_frame(8'd17, 8, 1'b0, 1'b0, 1'b1, -1);
        total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", rx_overrun); end
        total++; if (rx_fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count17 got=%0d exp=16", rx_fifo_count); end
        total++; if (rx_fifo_out !== 11'h001) begin bad++; $display("FAIL ovf_head got=%h exp=001", rx_fifo_out); end
        overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", rx_overrun); end
        // Stop bit is sampled 306 PCLKs after the first edge of the frame;
        // the push lands one cycle later, so pop is raised for that cycle.
        send_frame(8'd18, 8, 1'b0, 1'b0, 1'b1, 307);
        total++; if (rx_fifo_count !== 5'd16) begin bad++; $display("FAIL pushpop_count got=%0d exp=16", rx_fifo_count); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL pushpop_ovr got=%b exp=0", rx_overrun); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 11'(i + 2) : 11'h012;
            total++; if (rx_fifo_out !== exp) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, rx_fifo_out, exp); end
            rx_fifo_pop = 1'b1; @(negedge clk); rx_fifo_pop = 1'b0;
        end
        total++; if (rx_fifo_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", rx_fifo_empty); end
        rx_fifo_pop = 1'b1; @(negedge clk); rx_fifo_pop = 1'b0;
        total++; if (rx_fifo_count !== 5'd0) begin bad++; $display("FAIL pop_empty got=%0d exp=0", rx_fifo_count); end
        $display("test_overflow: 18 chars sent, 16 drained");
    endtask

    task automatic test_reset_midchar();
        LCR = 8'h03;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1);
        total++; if (rx_fifo_count !== 5'd1) begin bad++; $display("FAIL rstmid_pre got=%0d exp=1", rx_fifo_count); end
        fork
            send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, -1);
            begin
                repeat (150) @(negedge clk);
                PRESETn = 1'b0;
                repeat (2) @(negedge clk);
                total++; if (rx_fifo_empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%b exp=1", rx_fifo_empty); end
                PRESETn = 1'b1;
            end
        join
        repeat (40) @(negedge clk);
        total++; if (rx_fifo_count !== 5'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", rx_fifo_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        $display("test_reset_midchar: character discarded");
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_5bit();
        test_false_start();
        test_break();
        test_overflow();
        test_reset_midchar();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
